mem_arbiter: RTL and testbench

Two-master to one-slave request arbiter between the CPU instruction/data memory ports and the cached DRAM path (cache_control valid/ready port).
- Replaces ad-hoc combinational muxing of imem/dmem onto the cache with a registered, glitch-free grant.
- Guarantees one outstanding cache transaction at a time and routes each response only to its owner.
- Prevents instruction-fetch starvation under continuous data traffic.

---
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter with a registered grant, one outstanding
// transaction at a time, and alternating priority when both masters contend.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wmask,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [31:0] AddrMask = (ADDR_W >= 32) ? 32'hFFFF_FFFF :
                                     ((32'd1 << ADDR_W) - 32'd1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q;
  logic        last_dmem_q;  // previous grant went to the data port
  logic        m_valid_q;
  logic [31:0] m_addr_q;
  logic [3:0]  m_wmask_q;
  logic [31:0] m_wdata_q;
  logic        sel_dmem;

  // Data wins unless the instruction port is also waiting and data had the last grant.
  assign sel_dmem = d_valid & (~i_valid | ~last_dmem_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_dmem_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wmask_q   <= '0;
      m_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_valid || i_valid) begin
            m_valid_q   <= 1'b1;
            last_dmem_q <= sel_dmem;
            if (sel_dmem) begin
              state_q   <= StBusyD;
              m_addr_q  <= d_addr & AddrMask;
              m_wmask_q <= d_wmask;
              m_wdata_q <= d_wdata;
            end else begin
              state_q   <= StBusyI;
              m_addr_q  <= i_addr & AddrMask;
              m_wmask_q <= '0;
              m_wdata_q <= '0;
            end
          end
        end
        StBusyI, StBusyD: begin
          if (m_ready) begin
            state_q   <= StIdle;
            m_valid_q <= 1'b0;
            m_wmask_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wmask = m_wmask_q;
  assign m_wdata = m_wdata_q;

  assign i_ready = (state_q == StBusyI) & m_ready;
  assign d_ready = (state_q == StBusyD) & m_ready;
  assign i_rdata = i_ready ? m_rdata : '0;
  assign d_rdata = d_ready ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level arbitration model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready, d_valid, d_ready, m_valid, m_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  d_wmask, m_wmask;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] Mask = 32'h03FF_FFFF;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(26)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wmask(m_wmask),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic ne();
    @(negedge clk);
  endtask

  // Random-phase model: one outstanding transaction, owner 0=I 1=D, plus last grant owner.
  bit          busy, owner, last_owner, done_i, done_d, exp_ready_i, exp_ready_d;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wmask;

  initial begin
    reset = 1'b1; i_valid = 0; d_valid = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wmask = '0; d_wdata = '0; m_rdata = '0;

    // Reset and a single instruction fetch
    nx(); nx(); nx();
    ne();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wmask", 32'(m_wmask), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    nx(); reset = 0; i_valid = 1; i_addr = 32'h0000_0104;
    ne(); chk("t1_idle_m_valid", 32'(m_valid), 32'd0);
    nx(); ne();
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_addr", m_addr, 32'h0000_0104);
    chk("t1_m_wmask", 32'(m_wmask), 32'd0);
    nx(); m_ready = 1; m_rdata = 32'hDEAD_BEEF;
    ne();
    chk("t1_i_ready", 32'(i_ready), 32'd1);
    chk("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("t1_d_ready", 32'(d_ready), 32'd0);
    chk("t1_d_rdata", d_rdata, 32'd0);
    nx(); m_ready = 0; i_valid = 0;
    ne(); chk("t1_done_m_valid", 32'(m_valid), 32'd0);
    chk("t1_done_i_ready", 32'(i_ready), 32'd0);

    // Data write with upper address bits masked
    nx(); d_valid = 1; d_addr = 32'hFC00_0010; d_wmask = 4'b0011; d_wdata = 32'h1234_5678;
    ne(); nx(); ne();
    chk("t2_m_valid", 32'(m_valid), 32'd1);
    chk("t2_m_addr", m_addr, 32'h0000_0010);
    chk("t2_m_wmask", 32'(m_wmask), 32'd3);
    chk("t2_m_wdata", m_wdata, 32'h1234_5678);
    nx(); m_ready = 1; m_rdata = 32'h0BAD_F00D;
    ne();
    chk("t2_d_ready", 32'(d_ready), 32'd1);
    chk("t2_i_ready", 32'(i_ready), 32'd0);
    nx(); m_ready = 0; d_valid = 0;
    ne();
    chk("t2_d_ready_once", 32'(d_ready), 32'd0);
    chk("t2_wmask_clr", 32'(m_wmask), 32'd0);

    // Contention from reset: D, I, D, I with an idle gap before each grant
    nx(); reset = 1;
    nx(); reset = 0; i_valid = 1; d_valid = 1; i_addr = 32'h200; d_addr = 32'h300; d_wmask = 0;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      ne();
      while (!m_valid && w < 5) begin
        nx(); ne(); w++;
      end
      chk("t3_grant_seen", 32'(m_valid), 32'd1);
      chk("t3_idle_gap", 32'(w >= 1), 32'd1);
      chk("t3_order_addr", m_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
      nx(); m_ready = 1;
      ne();
      chk("t3_d_ready", 32'(d_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_i_ready", 32'(i_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      nx(); m_ready = 0;
      if (k == 3) begin
        i_valid = 0; d_valid = 0;
      end
    end

    // Address changes during BUSY_D are ignored
    nx(); d_valid = 1; d_addr = 32'h40;
    ne(); nx(); d_addr = 32'h80;
    ne(); chk("t4_addr_hold0", m_addr, 32'h40);
    nx(); ne(); chk("t4_addr_hold1", m_addr, 32'h40);
    nx(); m_ready = 1;
    ne(); chk("t4_addr_hold2", m_addr, 32'h40);
    chk("t4_d_ready", 32'(d_ready), 32'd1);
    nx(); m_ready = 0; d_valid = 0;

    // Reset mid-transaction aborts without a ready pulse
    nx(); i_valid = 1; i_addr = 32'h500;
    ne(); nx(); ne(); chk("t5_busy", 32'(m_valid), 32'd1);
    nx(); reset = 1;
    ne(); nx(); reset = 0; i_valid = 0;
    ne(); chk("t5_abort_m_valid", 32'(m_valid), 32'd0);
    nx(); m_ready = 1;
    ne();
    chk("t5_late_i_ready", 32'(i_ready), 32'd0);
    chk("t5_late_d_ready", 32'(d_ready), 32'd0);
    chk("t5_late_m_valid", 32'(m_valid), 32'd0);
    nx(); m_ready = 0;

    // Stray m_ready while idle
    nx(); m_ready = 1;
    ne();
    chk("t6_i_ready", 32'(i_ready), 32'd0);
    chk("t6_d_ready", 32'(d_ready), 32'd0);
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    nx(); m_ready = 0;
    ne(); chk("t6_stay_idle", 32'(m_valid), 32'd0);

    // Randomized traffic; last grant was reset to I by the mid-transaction reset
    busy = 0; owner = 0; last_owner = 0; done_i = 0; done_d = 0;
    exp_addr = '0; exp_wmask = '0; exp_wdata = '0;
    for (int c = 0; c < 2000; c++) begin
      nx();
      m_ready = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      if (done_i) begin i_valid = 0; done_i = 0; end
      if (done_d) begin d_valid = 0; done_d = 0; end
      if (!i_valid && $urandom_range(0, 3) == 0) begin
        i_valid = 1; i_addr = $urandom;
      end
      if (!d_valid && $urandom_range(0, 3) == 0) begin
        d_valid = 1; d_addr = $urandom; d_wmask = 4'($urandom); d_wdata = $urandom;
      end
      if (busy && !owner) i_addr = $urandom;
      if (busy && owner) begin d_addr = $urandom; d_wdata = $urandom; end
      ne();
      exp_ready_i = busy && !owner && m_ready;
      exp_ready_d = busy && owner && m_ready;
      chk("rnd_m_valid", 32'(m_valid), 32'(busy));
      if (busy) begin
        chk("rnd_m_addr", m_addr, exp_addr);
        chk("rnd_m_wmask", 32'(m_wmask), 32'(exp_wmask));
        chk("rnd_m_wdata", m_wdata, exp_wdata);
      end
      chk("rnd_i_ready", 32'(i_ready), 32'(exp_ready_i));
      chk("rnd_d_ready", 32'(d_ready), 32'(exp_ready_d));
      chk("rnd_i_rdata", i_rdata, exp_ready_i ? m_rdata : 32'd0);
      chk("rnd_d_rdata", d_rdata, exp_ready_d ? m_rdata : 32'd0);
      if (busy && m_ready) begin
        busy = 0;
        if (owner) done_d = 1; else done_i = 1;
      end else if (!busy && (i_valid || d_valid)) begin
        owner = d_valid && (!i_valid || !last_owner);
        last_owner = owner;
        busy = 1;
        exp_addr  = (owner ? d_addr : i_addr) & Mask;
        exp_wmask = owner ? d_wmask : 4'd0;
        exp_wdata = owner ? d_wdata : 32'd0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
